// File: rtl/band_capture_if.sv
// band_capture_if: sample stream into the capture block and its registered RAM write port.
// master = capture side (consumes samples, drives RAM), slave = source/RAM side.
interface band_capture_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  valid_in;
    logic [15:0]           data_in;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_din;

    modport master (
        input  valid_in, data_in,
        output mem_we, mem_addr, mem_din
    );

    modport slave (
        output valid_in, data_in,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/band_capture.sv
// band_capture: records a signed 16-bit sample stream into a single-port capture RAM,
// one-shot or looping, with peak tracking. Define BAND_CAPTURE_TRIGGER_EN for a level trigger.
module band_capture #(
    parameter int          MEM_DEPTH  = 4036,
    parameter int          ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter logic [15:0] THRESHOLD  = 16'd1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                stop,
    input  logic                loop,
    band_capture_if.master      bus,
    output logic                busy,
    output logic                done,
    output logic                wrapped,
    output logic [ADDR_WIDTH:0] sample_count,
    output logic [14:0]         peak_abs
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic                  loop_mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [14:0]           sample_abs;
    logic                  trigger_hit;
    logic                  start;
    logic                  capture_write;
    logic                  at_last;
    logic                  fill_end;

    // -32768 has no positive 16-bit twin, so it clamps to the largest magnitude.
    function automatic logic [14:0] abs_sat(input logic signed [15:0] x);
        if (x == 16'sh8000) return 15'h7fff;
        else if (x < 0)     return 15'(-x);
        else                return x[14:0];
    endfunction

    assign sample_abs = abs_sat(bus.data_in);

`ifdef BAND_CAPTURE_TRIGGER_EN
    assign trigger_hit = ({1'b0, sample_abs} >= THRESHOLD);
`else
    assign trigger_hit = 1'b1;
    logic unused_threshold;
    assign unused_threshold = ^THRESHOLD;
`endif

    assign start         = arm && (state == IDLE || state == DONE);
    assign capture_write = bus.valid_in &&
                           ((state == CAPTURE) || (state == ARMED && trigger_hit));
    assign at_last       = (addr == LAST_ADDR);
    assign fill_end      = capture_write && at_last && !loop_mode;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaulting every comb output first means no path leaves it unassigned,
        // so no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (arm) state_nxt = ARMED;
            end
            ARMED, CAPTURE: begin
                if (stop || fill_end)   state_nxt = DONE;
                else if (capture_write) state_nxt = CAPTURE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ARMED, CAPTURE: busy = 1'b1;
            DONE:           done = 1'b1;
            default:        ;
        endcase
    end

    // Write port and capture bookkeeping; the write registers and status share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            addr         <= '0;
            loop_mode    <= 1'b0;
            wrapped      <= 1'b0;
            sample_count <= '0;
            peak_abs     <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start) begin
                addr         <= '0;
                loop_mode    <= loop;
                wrapped      <= 1'b0;
                sample_count <= '0;
                peak_abs     <= '0;
            end else if (capture_write) begin
                bus.mem_we   <= 1'b1;
                bus.mem_addr <= addr;
                bus.mem_din  <= bus.data_in;
                addr         <= at_last ? '0 : addr + ADDR_WIDTH'(1);
                if (at_last && loop_mode)
                    wrapped <= 1'b1;
                if (sample_count != FULL_COUNT)
                    sample_count <= sample_count + (ADDR_WIDTH + 1)'(1);
                if (sample_abs > peak_abs)
                    peak_abs <= sample_abs;
            end
        end
    end

endmodule

// File: tb/tb_band_capture.sv
// tb_band_capture: vector table, hand-written corner sequences and a randomized run
// against a sample-counting reference model of band_capture (MEM_DEPTH = 8).
module tb_band_capture;

    localparam int          MEM_DEPTH = 8;
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [15:0] THRESHOLD = 16'd1024;
    localparam int          N_RANDOM  = 3000;

    typedef struct {
        logic        arm;
        logic        stop;
        logic        loop;
        logic        valid;
        logic [15:0] data;
        logic        we;
        int          addr;
        logic        busy;
        logic        done;
        int          count;
        int          peak;
        logic        wrapped;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm   = 1'b0;
    logic        stop  = 1'b0;
    logic        loop  = 1'b0;
    logic        busy;
    logic        done;
    logic        wrapped;
    logic [AW:0] sample_count;
    logic [14:0] peak_abs;

    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[$];

    // Reference model: a capture is a running count of accepted samples since arm.
    bit          m_active;
    bit          m_started;
    bit          m_done;
    bit          m_loop;
    bit          m_wrapped;
    int          m_total;
    int          m_peak;
    logic        e_we;
    int          e_addr;
    logic [15:0] e_din;

    band_capture_if #(.ADDR_WIDTH(AW)) bus ();

    band_capture #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_WIDTH(AW),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .stop        (stop),
        .loop        (loop),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .wrapped     (wrapped),
        .sample_count(sample_count),
        .peak_abs    (peak_abs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic s, input logic l, input logic v,
                         input logic [15:0] d);
        arm          = a;
        stop         = s;
        loop         = l;
        bus.valid_in = v;
        bus.data_in  = d;
        tick();
        arm          = 1'b0;
        stop         = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic b, input logic dn,
                                input int cnt, input int pk, input logic wr);
        check({tag, ".busy"},    32'(busy),         32'(b));
        check({tag, ".done"},    32'(done),         32'(dn));
        check({tag, ".count"},   32'(sample_count), 32'(cnt));
        check({tag, ".peak"},    32'(peak_abs),     32'(pk));
        check({tag, ".wrapped"}, 32'(wrapped),      32'(wr));
    endtask

    task automatic check_write(input string tag, input logic we, input int addr,
                               input logic [15:0] din);
        check({tag, ".we"}, 32'(bus.mem_we), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr));
            check({tag, ".din"},  32'(bus.mem_din),  32'(din));
        end
    endtask

    function automatic int abs_sat(input logic [15:0] d);
        int x;
        x = int'($signed(d));
        if (x < 0)     x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    function automatic void add(input logic a, input logic s, input logic l, input logic v,
                                input logic [15:0] d, input logic we, input int addr,
                                input logic b, input logic dn, input int cnt, input int pk,
                                input logic wr);
        vec_t r;
        r.arm = a;  r.stop = s;  r.loop = l;  r.valid = v;  r.data = d;
        r.we = we;  r.addr = addr;  r.busy = b;  r.done = dn;
        r.count = cnt;  r.peak = pk;  r.wrapped = wr;
        vecs.push_back(r);
    endfunction

    task automatic model_reset();
        m_active = 0; m_started = 0; m_done = 0; m_loop = 0; m_wrapped = 0;
        m_total = 0;  m_peak = 0;
    endtask

    task automatic model_step(input logic a, input logic s, input logic l, input logic v,
                              input logic [15:0] d);
        bit qual;
        e_we = 1'b0;
        if (m_active) begin
`ifdef BAND_CAPTURE_TRIGGER_EN
            qual = m_started || (abs_sat(d) >= int'(THRESHOLD));
`else
            qual = 1'b1;
`endif
            if (v && qual) begin
                e_we      = 1'b1;
                e_addr    = m_total % MEM_DEPTH;
                e_din     = d;
                m_total   = m_total + 1;
                m_started = 1;
                if (abs_sat(d) > m_peak) m_peak = abs_sat(d);
                if (m_total % MEM_DEPTH == 0) begin
                    if (m_loop) m_wrapped = 1;
                    else begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
            if (s && m_active) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (a) begin
            m_active = 1; m_started = 0; m_done = 0; m_loop = l;
            m_wrapped = 0; m_total = 0; m_peak = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        logic        a, s, l, v, prev_v;
        logic [15:0] d;
        int          exp_cnt;

        bus.valid_in = 1'b0;
        bus.data_in  = '0;

        // Reset state, held through two clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_write("reset", 1'b0, 0, 16'h0);
        check("reset.addr", 32'(bus.mem_addr), 32'd0);
        check("reset.din",  32'(bus.mem_din),  32'd0);
        check_status("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Valid in IDLE is ignored.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        check_write("idle_valid", 1'b0, 0, 16'h0);
        check_status("idle_valid", 1'b0, 1'b0, 0, 0, 1'b0);

`ifndef BAND_CAPTURE_TRIGGER_EN
        // One-shot fill, then peak saturation, via the vector table.
        add(1, 0, 0, 0, 16'd0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= MEM_DEPTH; i++) begin
            add(0, 0, 0, 1, 16'(i), 1, i - 1, i < MEM_DEPTH, i == MEM_DEPTH, i, i, 0);
            add(0, 0, 0, 0, 16'd0, 0, 0, i < MEM_DEPTH, i == MEM_DEPTH, i, i, 0);
        end
        add(0, 0, 0, 1, 16'd9, 0, 0, 0, 1, MEM_DEPTH, MEM_DEPTH, 0);
        add(1, 0, 0, 0, 16'd0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 16'hfffb, 1, 0, 1, 0, 1, 5, 0);
        add(0, 0, 0, 0, 16'd0,    0, 0, 1, 0, 1, 5, 0);
        add(0, 0, 0, 1, 16'd300,  1, 1, 1, 0, 2, 300, 0);
        add(0, 0, 0, 0, 16'd0,    0, 0, 1, 0, 2, 300, 0);
        add(0, 0, 0, 1, 16'h8000, 1, 2, 1, 0, 3, 32767, 0);
        add(0, 0, 0, 0, 16'd0,    0, 0, 1, 0, 3, 32767, 0);
        add(0, 0, 0, 1, 16'd12,   1, 3, 1, 0, 4, 32767, 0);
        add(0, 1, 0, 0, 16'd0,    0, 0, 0, 1, 4, 32767, 0);
        add(0, 0, 0, 1, 16'd7,    0, 0, 0, 1, 4, 32767, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].arm, vecs[i].stop, vecs[i].loop, vecs[i].valid, vecs[i].data);
            check_write($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data);
            check_status($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done,
                         vecs[i].count, vecs[i].peak, vecs[i].wrapped);
        end
`endif

        // Loop wrap: 10 samples into 8 words, then stop.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        check_status("wrap.arm", 1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= MEM_DEPTH + 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000 + 16'(i));
            check_write($sformatf("wrap%0d", i), 1'b1, (i - 1) % MEM_DEPTH, 16'h1000 + 16'(i));
            check_status($sformatf("wrap%0d", i), 1'b1, 1'b0,
                         (i > MEM_DEPTH) ? MEM_DEPTH : i, 16'h1000 + i, i >= MEM_DEPTH);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        check_status("wrap.stop", 1'b0, 1'b1, MEM_DEPTH, 16'h1000 + MEM_DEPTH + 2, 1'b1);

        // Stop together with valid at address 3: the sample lands, then nothing more.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h2000 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h2abc);
        check_write("stopv", 1'b1, 3, 16'h2abc);
        check_status("stopv", 1'b0, 1'b1, 4, 16'h2abc, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h3000);
            check_write($sformatf("stopv.after%0d", i), 1'b0, 0, 16'h0);
        end
        check_status("stopv.end", 1'b0, 1'b1, 4, 16'h2abc, 1'b0);

`ifdef BAND_CAPTURE_TRIGGER_EN
        // Trigger: only |x| >= THRESHOLD starts the capture.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd100);
        check_write("trig.100", 1'b0, 0, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, -16'sd1023);
        check_write("trig.m1023", 1'b0, 0, 16'h0);
        check_status("trig.m1023", 1'b1, 1'b0, 0, 0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, -16'sd1024);
        check_write("trig.m1024", 1'b1, 0, -16'sd1024);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd50);
        check_write("trig.50", 1'b1, 1, 16'd50);
        check_status("trig.50", 1'b1, 1'b0, 2, 1024, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
`endif

        // Reset while a write is on the bus clears everything at once.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h4321);
        check_write("rstmid.pre", 1'b1, 0, 16'h4321);
        rst_n = 1'b0;
        #1;
        check("rstmid.we",   32'(bus.mem_we),   32'd0);
        check("rstmid.addr", 32'(bus.mem_addr), 32'd0);
        check("rstmid.din",  32'(bus.mem_din),  32'd0);
        check_status("rstmid", 1'b0, 1'b0, 0, 0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        check_status("rstmid.arm", 1'b1, 1'b0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h5111);
        check_write("rstmid.first", 1'b1, 0, 16'h5111);
        check_status("rstmid.first", 1'b1, 1'b0, 1, 16'h5111, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        prev_v = 1'b0;
        for (int c = 0; c < N_RANDOM; c++) begin
            a = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 79) == 0);
            l = 1'($urandom_range(0, 1));
            v = !prev_v && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: case ($urandom_range(0, 3))
                       0: d = 16'h8000;
                       1: d = 16'h7fff;
                       2: d = 16'hffff;
                       default: d = 16'h0000;
                   endcase
                1: begin
                    d = THRESHOLD + 16'($urandom_range(0, 4)) - 16'd2;
                    if ($urandom_range(0, 1) == 1) d = -d;
                end
                default: d = 16'($urandom);
            endcase
            model_step(a, s, l, v, d);
            drive(a, s, l, v, d);
            exp_cnt = (m_total > MEM_DEPTH) ? MEM_DEPTH : m_total;
            check_write($sformatf("rnd%0d", c), e_we, e_addr, e_din);
            check_status($sformatf("rnd%0d", c), m_active, m_done, exp_cnt, m_peak, m_wrapped);
            prev_v = v;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
